// File: rtl/output_pkg.sv
// Shared widths and the lane-count to byte-enable mapping for the output packer.
package output_pkg;

    localparam int DIN_W      = 32;
    localparam int DOUT_W     = 128;
    localparam int LEN_W      = 16;
    localparam int RATIO      = DOUT_W / DIN_W;
    localparam int KEEP_W     = DOUT_W / 8;
    localparam int LANE_KEEP  = DIN_W / 8;
    localparam int LANE_CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    // One extra bit so a full beat (RATIO lanes) is representable.
    typedef logic [LANE_CNT_W:0] lanes_t;

    function automatic logic [KEEP_W-1:0] lane_keep_mask(input lanes_t lanes);
        logic [KEEP_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (i < int'(lanes)) begin
                mask[i*LANE_KEEP +: LANE_KEEP] = {LANE_KEEP{1'b1}};
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/output_packer.sv
// Packs DIN_W-wide drain results into DOUT_W-wide AXI-Stream beats with tkeep/tlast,
// ending frames on a configured beat count or an upstream tlast.
module output_packer
    import output_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_beats,
    input  logic [DIN_W-1:0]  s_axis_packer_tdata,
    input  logic              s_axis_packer_tvalid,
    input  logic              s_axis_packer_tlast,
    output logic              s_axis_packer_tready,
    output logic [DOUT_W-1:0] m_axis_packer_tdata,
    output logic              m_axis_packer_tvalid,
    input  logic              m_axis_packer_tready,
    output logic [KEEP_W-1:0] m_axis_packer_tkeep,
    output logic              m_axis_packer_tlast,
    output logic              frame_done
);

    logic [LANE_CNT_W-1:0] lane_cnt_p0;
    logic [LEN_W-1:0]      beat_cnt_p0;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      len_eff;
    logic [DOUT_W-1:0]     lane_buf_p0;
    logic [DOUT_W-1:0]     word_nxt;
    logic [KEEP_W-1:0]     keep_nxt;

    logic [DOUT_W-1:0]     data_p1;
    logic [KEEP_W-1:0]     keep_p1;
    logic                  last_p1;
    logic                  vld_p1;
    logic                  frame_done_p2;

    logic                  accept;
    logic                  frame_start;
    logic                  lane_full;
    logic                  complete;
    logic                  word_last;

    // Ready depends only on the output register, so no skid buffer is needed.
    assign s_axis_packer_tready = ~vld_p1 | m_axis_packer_tready;
    assign accept      = s_axis_packer_tvalid & s_axis_packer_tready;
    assign frame_start = (lane_cnt_p0 == '0) && (beat_cnt_p0 == '0);
    assign lane_full   = (lane_cnt_p0 == LANE_CNT_W'(RATIO - 1));
    assign complete    = accept & (lane_full | s_axis_packer_tlast);

    // The first word of a frame compares against the length being captured with it.
    assign len_eff   = frame_start ? cfg_beats : len_q;
    assign word_last = s_axis_packer_tlast |
                       ((len_eff != '0) && (beat_cnt_p0 == len_eff - LEN_W'(1)));

    always_comb begin
        word_nxt = lane_buf_p0;
        word_nxt[int'(lane_cnt_p0)*DIN_W +: DIN_W] = s_axis_packer_tdata;
        keep_nxt = lane_keep_mask(lanes_t'(lane_cnt_p0) + lanes_t'(1));
    end

    // Stage p0: lane accumulation and frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_p0 <= '0;
            beat_cnt_p0 <= '0;
            len_q       <= '0;
            lane_buf_p0 <= '0;
        end else if (accept) begin
            if (frame_start) begin
                len_q <= cfg_beats;
            end
            if (complete) begin
                lane_cnt_p0 <= '0;
                lane_buf_p0 <= '0;
                beat_cnt_p0 <= word_last ? '0 : beat_cnt_p0 + LEN_W'(1);
            end else begin
                lane_cnt_p0 <= lane_cnt_p0 + LANE_CNT_W'(1);
                lane_buf_p0 <= word_nxt;
            end
        end
    end

    // Stage p1: output beat register; stage p2: frame_done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1       <= '0;
            keep_p1       <= '0;
            last_p1       <= 1'b0;
            vld_p1        <= 1'b0;
            frame_done_p2 <= 1'b0;
        end else begin
            frame_done_p2 <= vld_p1 & m_axis_packer_tready & last_p1;
            if (complete) begin
                vld_p1  <= 1'b1;
                data_p1 <= word_nxt;
                keep_p1 <= keep_nxt;
                last_p1 <= word_last;
            end else if (m_axis_packer_tready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign m_axis_packer_tdata  = data_p1;
    assign m_axis_packer_tkeep  = keep_p1;
    assign m_axis_packer_tlast  = last_p1;
    assign m_axis_packer_tvalid = vld_p1;
    assign frame_done           = frame_done_p2;

endmodule

// File: tb/tb_output_packer.sv
// Directed scoreboard bench for output_packer: expected beats are queued by the
// stimulus thread and popped by a monitor on every downstream handshake.
module tb_output_packer;
    import output_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [LEN_W-1:0]  cfg_beats;
    logic [DIN_W-1:0]  s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic [DOUT_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic              frame_done;

    always #5 clk = ~clk;

    output_packer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cfg_beats            (cfg_beats),
        .s_axis_packer_tdata  (s_tdata),
        .s_axis_packer_tvalid (s_tvalid),
        .s_axis_packer_tlast  (s_tlast),
        .s_axis_packer_tready (s_tready),
        .m_axis_packer_tdata  (m_tdata),
        .m_axis_packer_tvalid (m_tvalid),
        .m_axis_packer_tready (m_tready),
        .m_axis_packer_tkeep  (m_tkeep),
        .m_axis_packer_tlast  (m_tlast),
        .frame_done           (frame_done)
    );

    typedef struct {
        logic [DOUT_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic              l;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   fd_cnt = 0;
    logic exp_fd = 1'b0;

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic chkk(input string name, input logic [KEEP_W-1:0] act, input logic [KEEP_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chkw(input string name, input logic [DOUT_W-1:0] act, input logic [DOUT_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [DOUT_W-1:0] w4(input logic [31:0] a3, input logic [31:0] a2,
                                             input logic [31:0] a1, input logic [31:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic push(input logic [DOUT_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
        exp_t e;
        e.d = d;
        e.k = k;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Present one word and return #1 after the edge that accepted it.
    task automatic send(input logic [31:0] d, input logic l);
        logic ok;
        int   n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        forever begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout word=%h waited=%0d cycles", d, n);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cfg_beats = '0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        m_tready  = 1'b1;
        fork
            begin : stim
                #1;
                chk1("rst_m_tvalid", m_tvalid, 1'b0);
                chkw("rst_m_tdata", m_tdata, '0);
                chkk("rst_m_tkeep", m_tkeep, '0);
                chk1("rst_m_tlast", m_tlast, 1'b0);
                chk1("rst_frame_done", frame_done, 1'b0);
                chk1("rst_s_tready", s_tready, 1'b1);
                idle(2);
                rst_n = 1'b1;
                idle(1);

                // Two-beat frame from the beat count, with latency probe
                cfg_beats = 16'd2;
                push(w4(3, 2, 1, 0), 16'hffff, 1'b0);
                push(w4(7, 6, 5, 4), 16'hffff, 1'b1);
                for (int i = 0; i < 8; i++) begin
                    send(i, 1'b0);
                    if (i == 2) chk1("latency_before", m_tvalid, 1'b0);
                    if (i == 3) chk1("latency_after", m_tvalid, 1'b1);
                end
                idle(3);

                // Upstream tlast flush of a two-lane word
                cfg_beats = 16'd0;
                push(w4(4, 3, 2, 1), 16'hffff, 1'b0);
                push(w4(0, 0, 6, 5), 16'h00ff, 1'b1);
                for (int i = 1; i <= 6; i++) send(i, (i == 6));
                idle(3);

                // Downstream stall with a full tlast word pending
                m_tready = 1'b0;
                push(w4(32'h14, 32'h13, 32'h12, 32'h11), 16'hffff, 1'b1);
                for (int i = 0; i < 4; i++) send(32'h11 + i, (i == 3));
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk1("hold_s_tready", s_tready, 1'b0);
                    chk1("hold_m_tvalid", m_tvalid, 1'b1);
                    chkw("hold_tdata", m_tdata, w4(32'h14, 32'h13, 32'h12, 32'h11));
                    chkk("hold_tkeep", m_tkeep, 16'hffff);
                    chk1("hold_tlast", m_tlast, 1'b1);
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
                @(negedge clk);
                chk1("release_s_tready", s_tready, 1'b1);
                idle(3);

                // Mid-frame cfg change ignored; next frames use the new length
                cfg_beats = 16'd3;
                push(w4(103, 102, 101, 100), 16'hffff, 1'b0);
                push(w4(107, 106, 105, 104), 16'hffff, 1'b0);
                push(w4(111, 110, 109, 108), 16'hffff, 1'b1);
                for (int i = 0; i < 12; i++) begin
                    send(100 + i, 1'b0);
                    if (i == 0) cfg_beats = 16'd1;
                end
                push(w4(203, 202, 201, 200), 16'hffff, 1'b1);
                push(w4(207, 206, 205, 204), 16'hffff, 1'b1);
                push(w4(211, 210, 209, 208), 16'hffff, 1'b1);
                push(w4(215, 214, 213, 212), 16'hffff, 1'b1);
                for (int i = 0; i < 16; i++) send(200 + i, (i == 11));
                idle(3);

                // Single-lane and three-lane flushes
                cfg_beats = 16'd0;
                push(w4(0, 0, 0, 9), 16'h000f, 1'b1);
                send(9, 1'b1);
                push(w4(0, 9, 8, 7), 16'h0fff, 1'b1);
                send(7, 1'b0);
                send(8, 1'b0);
                send(9, 1'b1);
                idle(3);

                // Asynchronous reset drops a pending beat without a handshake
                m_tready = 1'b0;
                for (int i = 0; i < 4; i++) send(40 + i, 1'b0);
                chk1("pending_before_rst", m_tvalid, 1'b1);
                #2;
                rst_n = 1'b0;
                #1;
                chk1("async_rst_m_tvalid", m_tvalid, 1'b0);
                chkw("async_rst_m_tdata", m_tdata, '0);
                chk1("async_rst_s_tready", s_tready, 1'b1);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                m_tready = 1'b1;
                idle(1);

                // Reset after a partial word leaves no stale lanes
                send(50, 1'b0);
                send(51, 1'b0);
                #2;
                rst_n = 1'b0;
                #1;
                chk1("partial_rst_m_tvalid", m_tvalid, 1'b0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                idle(1);
                push(w4(13, 12, 11, 10), 16'hffff, 1'b0);
                for (int i = 10; i <= 13; i++) send(i, 1'b0);

                for (int c = 0; c < 50; c++) begin
                    if (exp_q.size() == 0) break;
                    @(negedge clk);
                end
                idle(3);
                chki("queue_empty", exp_q.size(), 0);
                chki("frame_done_count", fd_cnt, 10);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        exp_fd = 1'b0;
                    end else begin
                        chk1("frame_done", frame_done, exp_fd);
                        if (frame_done) fd_cnt++;
                        exp_fd = m_tvalid & m_tready & m_tlast;
                        if (m_tvalid && m_tready) begin
                            if (exp_q.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_beat actual=%h required=none", m_tdata);
                            end else begin
                                exp_t e;
                                e = exp_q.pop_front();
                                chkw("beat_tdata", m_tdata, e.d);
                                chkk("beat_tkeep", m_tkeep, e.k);
                                chk1("beat_tlast", m_tlast, e.l);
                            end
                        end
                    end
                end
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/output_packer.md
Name: output_packer

Overview:
- Upstream neighbour of the 128-bit PS output stage.
- Collects narrow convolution results (one DIN_W word per handshake) from the systolic array drain path and packs them into DOUT_W-bit AXI-Stream beats.
- Drives tkeep and tlast so the DMA sees correct frame boundaries and byte enables.
- Frames end on a configured beat count or on an upstream tlast, whichever comes first.

Parameters:
- DIN_W, 32, input lane width in bits; must be a multiple of 8.
- DOUT_W, 128, output beat width in bits; must be a multiple of DIN_W.
- LEN_W, 16, width of the frame-length configuration.
- Derived: RATIO = DOUT_W/DIN_W (4); KEEP_W = DOUT_W/8 (16); LANE_KEEP = DIN_W/8 (4).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_beats  in  LEN_W  output beats per frame; 0 means frames end only on s_axis_packer_tlast.
- s_axis_packer_tdata  in  DIN_W  result word.
- s_axis_packer_tvalid  in  1  input valid.
- s_axis_packer_tlast  in  1  last word of the upstream frame.
- s_axis_packer_tready  out  1  input ready.
- m_axis_packer_tdata  out  DOUT_W  packed beat.
- m_axis_packer_tvalid  out  1  output valid.
- m_axis_packer_tready  in  1  output ready.
- m_axis_packer_tkeep  out  KEEP_W  byte enables.
- m_axis_packer_tlast  out  1  last beat of the frame.
- frame_done  out  1  one-cycle pulse when a tlast beat is accepted downstream.

Behaviour:
- Reset: all outputs 0, lane_cnt = 0, beat_cnt = 0, pack register = 0, len_q = 0. The only exception is s_axis_packer_tready, which is 1 because the output register is empty.
- Ready rule:
  - s_axis_packer_tready = ~m_axis_packer_tvalid | m_axis_packer_tready.
  - Combinational from m_axis_packer_tready only; no path from s_axis_packer_tvalid.
- Input acceptance (s valid & ready):
  - The word is written into lane lane_cnt of the pack register.
  - Lane 0 occupies bits [DIN_W-1:0], so the first word is least significant.
  - A word completes when either:
    - lane_cnt == RATIO-1, or
    - s_axis_packer_tlast == 1.
  - On an incomplete word, lane_cnt increments.
- Word completion, registered on the same edge as acceptance:
  - m_axis_packer_tdata = packed lanes; lanes not written in this word are 0.
  - m_axis_packer_tkeep has LANE_KEEP ones per filled lane, lower lanes first. A full word gives 16'hffff; a 2-lane flush gives 16'h00ff.
  - m_axis_packer_tlast = s_axis_packer_tlast | (len_q != 0 & beat_cnt == len_q-1).
  - m_axis_packer_tvalid = 1.
  - lane_cnt resets to 0.
  - beat_cnt resets to 0 if tlast, else increments.
- Latency: one cycle from accepting the completing input word to m_axis_packer_tvalid.
- Throughput: one input word per cycle while downstream is ready, i.e. one output beat per RATIO cycles.
- Output hold: while m_axis_packer_tvalid & ~m_axis_packer_tready, tdata, tkeep and tlast stay stable.
- Output clear: on a downstream handshake with no new word completing in that cycle, m_axis_packer_tvalid drops to 0.
- len_q:
  - Captures cfg_beats when lane_cnt == 0, beat_cnt == 0 and an input word is accepted (the start of a frame).
  - Changes to cfg_beats mid-frame are ignored.
- frame_done = registered m_axis_packer_tvalid & m_axis_packer_tready & m_axis_packer_tlast.
- Boundary conditions:
  - Upstream tlast with lane_cnt == RATIO-1 is a normal full word with tlast set.
  - Beat-count tlast and upstream tlast in the same word produce a single tlast; beat_cnt resets once.
  - beat_cnt saturates never: it wraps only via tlast. With len_q == 0 and no upstream tlast, beat_cnt wraps at 2^LEN_W without asserting tlast.
  - Reset asserted mid-frame clears the partial word and both counters immediately. The partial data is discarded with no flush.

Decomposition:
- Shared package output_pkg: DIN_W, DOUT_W, LEN_W defaults, derived RATIO, KEEP_W, LANE_KEEP, and the lane-keep mask function (lanes filled → tkeep).
- No sub-module: lane packing, counters and the single output register fit in one module.
- A separate skid buffer is not needed, because tready has no combinational path from the input side.

Test Plan:
- cfg_beats = 2, inputs 0..7 back-to-back, m_tready = 1 → two beats.
  - Beat 0: tdata = {3,2,1,0}, tkeep = ffff, tlast = 0.
  - Beat 1: tdata = {7,6,5,4}, tkeep = ffff, tlast = 1.
  - frame_done pulses once; the first beat appears one cycle after input 3 is accepted.
- cfg_beats = 0, inputs 1..6 with tlast on 6 → beats {4,3,2,1} (tkeep ffff, tlast 0), then {0,0,6,5} (tkeep 00ff, tlast 1).
- m_tready held low 5 cycles while a beat is pending → s_tready = 0 throughout; m_tdata, tkeep and tlast unchanged. The first cycle m_tready = 1 accepts the beat and s_tready = 1.
- cfg_beats = 3, then cfg_beats changed to 1 after the first input → tlast on the third beat; the next frame uses 1 (tlast on every beat).
- Single input 9 with tlast, lane_cnt = 0 → beat {0,0,0,9}, tkeep 000f, tlast 1.
- rst_n low after 2 inputs of a word → m_tvalid = 0 immediately. Subsequent inputs 10..13 → beat {13,12,11,10} with tkeep ffff; no stale lanes.
